// File: rtl/cnn_feeder_pkg.sv
// Shared types and constants for the lane-CNN frame feeder.
package cnn_feeder_pkg;

  localparam int IMG_W_DEF = 32;
  localparam int IMG_H_DEF = 32;
  localparam int PIX_W     = 8;
  localparam int RES_W     = 48;
  localparam logic [31:0] CNN_TIMEOUT_TAG = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT_BUSY,
    ST_STREAM,
    ST_WAIT_RESULT,
    ST_OUTPUT,
    ST_WAIT_IDLE
  } feeder_state_t;

  // The CNN reports a watchdog abort by placing the tag in the upper 32 result bits.
  function automatic logic is_timeout_tag(input logic signed [RES_W-1:0] res);
    return res[RES_W-1:RES_W-32] == CNN_TIMEOUT_TAG;
  endfunction

endpackage

// File: rtl/feeder_frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port, array not reset.
module feeder_frame_ram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cnn_frame_feeder.sv
// Frame feeder: buffers one host frame, streams it into the lane CNN and returns the
// captured 48-bit lane result to the host over valid/ready.
module cnn_frame_feeder
  import cnn_feeder_pkg::*;
#(
  parameter int IMG_W        = IMG_W_DEF,
  parameter int IMG_H        = IMG_H_DEF,
  parameter int PIX_GAP      = 0,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [PIX_W-1:0]        s_data,
  input  logic                    s_last,
  output logic                    cnn_start,
  output logic                    cnn_pixel_valid,
  output logic [PIX_W-1:0]        cnn_pixel,
  input  logic                    cnn_busy,
  input  logic                    cnn_result_valid,
  input  logic signed [RES_W-1:0] cnn_result,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [RES_W-1:0] m_result,
  output logic                    m_timeout,
  output logic                    frame_err
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX);
  localparam int GW   = $clog2(PIX_GAP + 2);
  localparam int TW   = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(NPIX - 1);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(PIX_GAP);
  localparam logic [TW-1:0] TMR_LAST   = TW'(BUSY_TIMEOUT - 1);

  feeder_state_t state, state_nxt;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] busy_tmr;
  logic          wr_en, rd_en_p0, vld_p1, rv_d1, rv_rise;
  logic [PIX_W-1:0] pix_p1;

  feeder_frame_ram #(.DEPTH(NPIX), .DATA_W(PIX_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (s_data),
    .re    (rd_en_p0),
    .raddr (rd_addr),
    .rdata (pix_p1)
  );

  assign rv_rise = cnn_result_valid && !rv_d1;

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    cnn_start = 1'b0;
    m_valid   = 1'b0;
    wr_en     = 1'b0;
    rd_en_p0  = 1'b0;
    case (state)
      ST_LOAD: begin
        s_ready = 1'b1;
        wr_en   = s_valid;
        if (s_valid && wr_addr == LAST_ADDR) state_nxt = ST_START;
      end
      ST_START: begin
        cnn_start = 1'b1;
        state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (cnn_busy)                  state_nxt = ST_STREAM;
        else if (busy_tmr == TMR_LAST) state_nxt = ST_START;
      end
      ST_STREAM: begin
        rd_en_p0 = (gap_cnt == '0);
        if (rd_en_p0 && rd_addr == LAST_ADDR) state_nxt = ST_WAIT_RESULT;
      end
      ST_WAIT_RESULT: begin
        if (rv_rise) state_nxt = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        m_valid = 1'b1;
        if (m_ready) state_nxt = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (!cnn_busy) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // p0 -> p1: RAM read data and its valid leave the stream stage together
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_LOAD;
      wr_addr   <= '0;
      rd_addr   <= '0;
      gap_cnt   <= '0;
      busy_tmr  <= '0;
      vld_p1    <= 1'b0;
      rv_d1     <= 1'b0;
      frame_err <= 1'b0;
      m_result  <= '0;
      m_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      vld_p1    <= rd_en_p0;
      rv_d1     <= cnn_result_valid;
      frame_err <= wr_en && s_last && (wr_addr != LAST_ADDR);

      if (wr_en)
        wr_addr <= (s_last || wr_addr == LAST_ADDR) ? '0 : wr_addr + AW'(1);
      else if (state == ST_WAIT_IDLE && !cnn_busy)
        wr_addr <= '0;

      if (state == ST_START) begin
        busy_tmr <= '0;
        gap_cnt  <= '0;
      end else if (state == ST_WAIT_BUSY) begin
        busy_tmr <= busy_tmr + TW'(1);
      end

      if (state == ST_STREAM) begin
        if (rd_en_p0) begin
          gap_cnt <= GAP_RELOAD;
          rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + AW'(1);
        end else begin
          gap_cnt <= gap_cnt - GW'(1);
        end
      end

      // Only a fresh edge counts; a level left high from an earlier frame is stale.
      if (state == ST_WAIT_RESULT && rv_rise) begin
        m_result  <= cnn_result;
        m_timeout <= is_timeout_tag(cnn_result);
      end
    end
  end

  assign cnn_pixel_valid = vld_p1;
  assign cnn_pixel       = vld_p1 ? pix_p1 : '0;

endmodule

// File: doc/cnn_frame_feeder.md
# cnn_frame_feeder

Upstream stage of the lane-detection CNN top. It accepts a 32×32 8-bit grayscale frame from the host byte stream and holds it in an internal frame RAM. It then issues a one-cycle start pulse to the CNN, streams the stored pixels into it, captures the 48-bit lane result and returns that result to the host over a valid/ready handshake.

## Interface
- `IMG_W`, default 32: frame width in pixels.
- `IMG_H`, default 32: frame height in pixels. `NPIX = IMG_W*IMG_H` (1024).
- `PIX_GAP`, default 0: idle cycles inserted between streamed pixels.
- `BUSY_TIMEOUT`, default 16: cycles to wait for `cnn_busy` after a start pulse.
- `clk` in 1: single clock.
- `rst` in 1: **synchronous, active-low** reset.
- `s_valid` in 1: host pixel byte valid.
- `s_ready` out 1: feeder can accept a byte.
- `s_data` in 8: pixel, raster order.
- `s_last` in 1: marks the final byte of a frame.
- `cnn_start` out 1: one-cycle start pulse to the CNN.
- `cnn_pixel_valid` out 1: qualifies `cnn_pixel`.
- `cnn_pixel` out 8: streamed pixel.
- `cnn_busy` in 1: CNN is not idle.
- `cnn_result_valid` in 1: CNN result valid; held high for many cycles.
- `cnn_result` in 48 signed: CNN lane result.
- `m_valid` out 1: result available to host.
- `m_ready` in 1: host accepts the result.
- `m_result` out 48 signed: captured result.
- `m_timeout` out 1: result carries the CNN timeout tag, valid with `m_valid`.
- `frame_err` out 1: one-cycle pulse when a short frame is dropped.

## Operation
States run in this order: LOAD → START → WAIT_BUSY → STREAM → WAIT_RESULT → OUTPUT → WAIT_IDLE → LOAD.
- **LOAD**
  - `s_ready`=1.
  - Each `s_valid&&s_ready` writes `s_data` to `ram[wr_addr]`, then `wr_addr++`.
  - `s_last`=1 with `wr_addr<NPIX-1`: frame dropped, `wr_addr`←0, `frame_err` pulses on the next cycle, stay in LOAD.
  - Byte at `wr_addr==NPIX-1` completes the frame regardless of `s_last`, then go to START.
- **START**: `cnn_start`=1 for exactly one cycle, timer cleared, go to WAIT_BUSY.
- **WAIT_BUSY**
  - `cnn_busy`=1: go to STREAM.
  - Timer reaches `BUSY_TIMEOUT`: return to START, which re-pulses start. This repeats indefinitely.
- **STREAM**
  - Reads `ram[0..NPIX-1]` in order.
  - One pixel every `PIX_GAP+1` cycles.
  - After pixel `NPIX-1` is presented, go to WAIT_RESULT.
- **WAIT_RESULT**
  - A rising edge of `cnn_result_valid` (`cnn_result_valid && !rv_d1`) captures `cnn_result` into `m_result`.
  - `m_timeout` ← (`cnn_result[47:16]==32'hDEADBEEF`).
  - Go to OUTPUT.
  - A level already high on entry is ignored; it is treated as stale from a prior frame.
- **OUTPUT**
  - `m_valid`=1; `m_result` and `m_timeout` are held stable.
  - On `m_valid&&m_ready`, go to WAIT_IDLE.
- **WAIT_IDLE**: once `cnn_busy`=0, clear `wr_addr` and go to LOAD.
- `s_ready`=0 in every state except LOAD. Host bytes are never accepted while a frame is in flight.

## Timing
- Reset (`rst`=0 at a `clk` edge):
  - State → LOAD; `wr_addr`, `rd_addr` and timers → 0.
  - All outputs → 0, except `s_ready`=1 in the cycle after release.
  - RAM contents are not cleared.
- Reset mid-STREAM aborts the frame. The CNN recovers through its own reset or timeout; the feeder does not drive it further.
- RAM uses a synchronous read with 1-cycle latency. `cnn_pixel_valid` is a 1-cycle-delayed copy of the read enable, so it is aligned with `cnn_pixel`.
- Cycle timing of the CNN handoff:
  - `cnn_start` is high in cycle t.
  - The earliest `cnn_busy` is at t+1.
  - The first `cnn_pixel_valid` is no earlier than t+3.
- With `PIX_GAP=0` the stream is exactly `NPIX` consecutive valid cycles.
- `cnn_pixel_valid` is never high outside STREAM plus the 1-cycle drain.
- Host-side latency: the last accepted byte (cycle L) leads to `cnn_start` at L+1.
- `m_valid` rises 1 cycle after the captured `cnn_result_valid` edge.
- Simultaneous `s_valid` and `s_last` on byte 0: the frame is dropped and `frame_err` pulses.

## Structure
- Shared package `cnn_feeder_pkg`:
  - state enum `feeder_state_t`;
  - `IMG_W`/`IMG_H` defaults;
  - `CNN_TIMEOUT_TAG = 32'hDEADBEEF`;
  - result width 48.
- Sub-module `feeder_frame_ram`: `NPIX`×8 simple dual-port RAM with one write port, one synchronous-read port, and no reset on the array.
- The top holds the FSM, address counters, gap counter, busy timer and result register.

## Test plan
- **Normal frame**:
  - Stimulus: 1024 bytes `i[7:0]` with `s_last` on the last byte; CNN model asserts busy 1 cycle after start and returns `cnn_result`=48'sd-1234 held for 1000 cycles.
  - Required: exactly one `cnn_start`, 1024 `cnn_pixel_valid` cycles carrying 0..255 repeating, `m_result`=-1234, `m_timeout`=0.
- **Short frame**:
  - Stimulus: `s_last` on byte 99.
  - Required: `frame_err` is one pulse, no `cnn_start`; a following full frame proceeds normally from address 0.
- **Busy timeout**:
  - Stimulus: CNN model ignores the first start; `BUSY_TIMEOUT`=16.
  - Required: a second `cnn_start` exactly 17 cycles after the first, then normal streaming.
- **Gap and timeout tag**:
  - Stimulus: `PIX_GAP`=2; result `48'hDEAD_BEEF_0400`.
  - Required: pixels spaced every 3 cycles; `m_timeout`=1.
- **Backpressure and stale valid**:
  - Stimulus: `m_ready` low for 50 cycles; `cnn_result_valid` already high on entry to WAIT_RESULT, and no fresh rising edge arrives.
  - Required: no capture, and `m_valid` stays 0, until a rising edge occurs; after that `m_result` is stable under backpressure and `s_ready` stays 0 until `cnn_busy` falls.
- **Reset mid-stream**:
  - Stimulus: `rst`=0 at pixel 500.
  - Required: next cycle `cnn_pixel_valid`=0, `m_valid`=0, `s_ready`=1 after release.
